// File: rtl/mem_access_ctrl.sv
// Memory-stage load/store controller for a word-organised, big-endian, byte-laned RAM with LL/SC link bit.
// Latency: request accepted at E0, RAM access in E0-E1, registered response valid in E1-E2 (2 cycles).
// Backpressure: req_ready is high only in IDLE, so at most one request is in flight (one per 2 cycles).
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              llbit_clear,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [3:0]        ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_exc,
  output logic              resp_exc_store,
  output logic              llbit
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;
  localparam logic [3:0] OP_LL  = 4'd8;
  localparam logic [3:0] OP_SC  = 4'd9;

  state_t              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic                resp_exc_q, resp_exc_d;
  logic                resp_exc_store_q, resp_exc_store_d;
  logic                llbit_q, llbit_d;

  // Decode of the registered request.
  logic                op_legal;
  logic                op_load;
  logic                op_store;
  logic                op_signed;
  size_t               op_size;
  logic                misaligned;
  logic [3:0]          lane_sel;
  logic [31:0]         lane_wdata;
  logic                sc_ok;
  logic                do_access;
  logic                in_access;
  logic [7:0]          load_byte;
  logic [15:0]         load_half;
  logic [31:0]         load_val;

  // Classify the held opcode: legality, direction, access size and extension.
  always_comb begin
    op_legal  = 1'b1;
    op_load   = 1'b0;
    op_store  = 1'b0;
    op_signed = 1'b0;
    op_size   = SZ_WORD;
    case (op_q)
      OP_LB:   begin op_load  = 1'b1; op_signed = 1'b1; op_size = SZ_BYTE; end
      OP_LBU:  begin op_load  = 1'b1; op_size = SZ_BYTE; end
      OP_LH:   begin op_load  = 1'b1; op_signed = 1'b1; op_size = SZ_HALF; end
      OP_LHU:  begin op_load  = 1'b1; op_size = SZ_HALF; end
      OP_LW:   begin op_load  = 1'b1; end
      OP_SB:   begin op_store = 1'b1; op_size = SZ_BYTE; end
      OP_SH:   begin op_store = 1'b1; op_size = SZ_HALF; end
      OP_SW:   begin op_store = 1'b1; end
      OP_LL:   begin op_load  = 1'b1; end
      OP_SC:   begin op_store = 1'b1; end
      default: begin op_legal = 1'b0; end
    endcase
  end

  // Alignment check, big-endian lane selection and lane-replicated store data.
  always_comb begin
    misaligned = 1'b0;
    lane_sel   = 4'b1111;
    lane_wdata = wdata_q;
    case (op_size)
      SZ_BYTE: begin
        lane_sel   = 4'b1000 >> addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        misaligned = addr_q[0];
        lane_sel   = addr_q[1] ? 4'b0011 : 4'b1100;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        misaligned = |addr_q[1:0];
      end
    endcase
  end

  // SC only touches the RAM when the link survived into its access cycle.
  assign in_access = (state_q == S_ACCESS);
  assign sc_ok     = (op_q == OP_SC) && llbit_q && !llbit_clear;
  assign do_access = op_legal && !misaligned && ((op_q != OP_SC) || sc_ok);

  // Drive the RAM port; enables are gated with reset so a reset mid-access cannot write.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_sel   = 4'b0000;
    ram_addr  = '0;
    ram_wdata = 32'h0;
    if (in_access && do_access && !rst) begin
      ram_ce   = 1'b1;
      ram_we   = op_store;
      ram_sel  = lane_sel;
      ram_addr = {addr_q[ADDR_W-1:2], 2'b00};
      if (op_store) begin
        ram_wdata = lane_wdata;
      end
    end
  end

  // Extract the addressed lane(s) from the read word and extend to 32 bits.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    load_byte = ram_rdata[31:24];
      2'd1:    load_byte = ram_rdata[23:16];
      2'd2:    load_byte = ram_rdata[15:8];
      default: load_byte = ram_rdata[7:0];
    endcase
    load_half = addr_q[1] ? ram_rdata[15:0] : ram_rdata[31:16];
    case (op_size)
      SZ_BYTE: load_val = {{24{op_signed & load_byte[7]}}, load_byte};
      SZ_HALF: load_val = {{16{op_signed & load_half[15]}}, load_half};
      default: load_val = ram_rdata;
    endcase
  end

  // Next-state, request capture, response formation and link-bit update.
  always_comb begin
    state_d          = state_q;
    op_d             = op_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    resp_valid_d     = 1'b0;
    resp_data_d      = 32'h0;
    resp_exc_d       = 1'b0;
    resp_exc_store_d = 1'b0;
    llbit_d          = llbit_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_ACCESS;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      S_ACCESS: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b1;
        if (op_legal) begin
          if (misaligned) begin
            resp_exc_d       = 1'b1;
            resp_exc_store_d = op_store;
          end else if (op_load) begin
            resp_data_d = load_val;
            if (op_q == OP_LL) begin
              llbit_d = 1'b1;
            end
          end else if (op_q == OP_SC) begin
            resp_data_d = {31'h0, sc_ok};
            llbit_d     = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // An exception/ERET clear overrides any link set in the same cycle.
    if (llbit_clear) begin
      llbit_d = 1'b0;
    end
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      op_q             <= 4'h0;
      addr_q           <= '0;
      wdata_q          <= 32'h0;
      resp_valid_q     <= 1'b0;
      resp_data_q      <= 32'h0;
      resp_exc_q       <= 1'b0;
      resp_exc_store_q <= 1'b0;
      llbit_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      op_q             <= op_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      resp_valid_q     <= resp_valid_d;
      resp_data_q      <= resp_data_d;
      resp_exc_q       <= resp_exc_d;
      resp_exc_store_q <= resp_exc_store_d;
      llbit_q          <= llbit_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign resp_exc       = resp_exc_q;
  assign resp_exc_store = resp_exc_store_q;
  assign llbit          = llbit_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte-array reference model, scoreboard queue, decoupled monitor.
// Responses are checked for data, exception flags, link bit and 2-cycle latency.
// RAM port activity is checked during each access cycle against the model's expected lanes.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        llbit_clear = 1'b0;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic        resp_valid, resp_exc, resp_exc_store, llbit;
  logic [31:0] resp_data;

  mem_access_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .llbit_clear(llbit_clear),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_exc(resp_exc),
    .resp_exc_store(resp_exc_store), .llbit(llbit)
  );

  always #5 clk = ~clk;

  // Word-organised RAM seen by the DUT (256 bytes).
  logic [31:0] ram_w [0:63];
  assign ram_rdata = ram_w[ram_addr[7:2]];
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      for (int l = 0; l < 4; l++)
        if (ram_sel[l]) ram_w[ram_addr[7:2]][8*l +: 8] <= ram_wdata[8*l +: 8];
    end
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: byte-addressed memory and link bit.
  logic [7:0] ref_mem [0:255];
  bit         ref_ll = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        exc;
    logic        exc_store;
    logic        ll;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    ref_word = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
  endfunction

  // Monitor: every response pulse pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("resp_latency", cycle, e.cyc);
          chk("resp_data", resp_data, e.data);
          chk("resp_exc", resp_exc, e.exc);
          if (e.exc) chk("resp_exc_store", resp_exc_store, e.exc_store);
          chk("llbit_after_resp", llbit, e.ll);
        end
      end
    end
  end

  // Issue one request; clr_acc is the llbit_clear level held during its access cycle.
  task automatic issue(input logic [3:0] op, input int a, input logic [31:0] wd, input bit clr_acc);
    exp_t        e;
    bit          legal, is_st, mis, ce, ok;
    int          sz;
    logic [31:0] v;
    logic [3:0]  esel;
    legal = (op <= 4'd9);
    is_st = (op == 4'd5) || (op == 4'd6) || (op == 4'd7) || (op == 4'd9);
    sz    = (op == 4'd0 || op == 4'd1 || op == 4'd5) ? 1 :
            (op == 4'd2 || op == 4'd3 || op == 4'd6) ? 2 : 4;
    mis   = legal && ((a % sz) != 0);
    e.data = 32'h0; e.exc = 1'b0; e.exc_store = 1'b0;
    ce = 1'b0; esel = 4'b0;
    if (!legal) begin
      ce = 1'b0;
    end else if (mis) begin
      e.exc = 1'b1; e.exc_store = is_st;
    end else if (!is_st) begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v = (v << 8) | {24'h0, ref_mem[a+i]};
      if (op == 4'd0 && v[7])  v = v | 32'hFFFFFF00;
      if (op == 4'd2 && v[15]) v = v | 32'hFFFF0000;
      e.data = v; ce = 1'b1;
      if (op == 4'd8) ref_ll = 1'b1;
    end else begin
      ok = (op != 4'd9) || (ref_ll && !clr_acc);
      if (ok) begin
        ce = 1'b1;
        for (int i = 0; i < sz; i++) ref_mem[a+i] = 8'(wd >> (8*(sz-1-i)));
      end
      if (op == 4'd9) begin e.data = {31'h0, ok}; ref_ll = 1'b0; end
    end
    if (clr_acc) ref_ll = 1'b0;
    e.ll = ref_ll;
    if (ce) for (int i = 0; i < sz; i++) esel[3 - ((a+i) % 4)] = 1'b1;

    @(negedge clk);
    chk("req_ready_before_issue", req_ready, 1'b1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; llbit_clear = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom; llbit_clear = clr_acc;
    #1;
    chk("req_ready_in_access", req_ready, 1'b0);
    chk("ram_ce", ram_ce, ce);
    chk("ram_we", ram_we, ce && is_st);
    chk("ram_sel", ram_sel, esel);
    if (ce) chk("ram_addr", ram_addr, a & ~3);
    if (ce && is_st)
      for (int l = 0; l < 4; l++)
        if (esel[l]) chk("ram_wdata_lane", ram_wdata[8*l +: 8], ref_mem[(a & ~3) + 3 - l]);
    e.cyc = cycle + 1;
    exp_q.push_back(e);
    @(negedge clk);
    llbit_clear = 1'b0;
    #1;
    chk("ram_ce_idle", ram_ce, 1'b0);
  endtask

  // Pulse llbit_clear for one idle cycle.
  task automatic idle_clear();
    @(negedge clk);
    llbit_clear = 1'b1;
    @(negedge clk);
    llbit_clear = 1'b0;
    ref_ll = 1'b0;
    chk("llbit_after_idle_clear", llbit, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = $urandom;
      ram_w[i] = w;
      for (int j = 0; j < 4; j++) ref_mem[4*i+j] = w[31-8*j -: 8];
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_exc", resp_exc, 1'b0);
    chk("rst_resp_exc_store", resp_exc_store, 1'b0);
    chk("rst_llbit", llbit, 1'b0);
    chk("rst_ram_ce", ram_ce, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_sel", ram_sel, 4'b0);
    rst = 1'b0;

    // Reset during a SW access: no write, no response.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd7; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_abort_ram_ce", ram_ce, 1'b0);
    chk("rst_abort_ram_we", ram_we, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_ll = 1'b0;
    chk("rst_abort_mem_unchanged", ram_w[4], ref_word(16));
    chk("rst_abort_req_ready", req_ready, 1'b1);
    chk("rst_abort_llbit", llbit, 1'b0);

    // Directed scenarios.
    issue(4'd7, 32'h20, 32'h12345678, 1'b0);   // SW
    issue(4'd4, 32'h20, 32'h0, 1'b0);          // LW
    issue(4'd5, 32'h21, 32'h00000080, 1'b0);   // SB
    issue(4'd0, 32'h21, 32'h0, 1'b0);          // LB
    issue(4'd1, 32'h21, 32'h0, 1'b0);          // LBU
    issue(4'd2, 32'h22, 32'h0, 1'b0);          // LH
    issue(4'd4, 32'h22, 32'h0, 1'b0);          // LW misaligned
    issue(4'd6, 32'h23, 32'h0000BEEF, 1'b0);   // SH misaligned
    issue(4'd8, 32'h30, 32'h0, 1'b0);          // LL
    issue(4'd9, 32'h30, 32'hA5A5A5A5, 1'b0);   // SC ok
    issue(4'd9, 32'h30, 32'h5A5A5A5A, 1'b0);   // SC fail
    issue(4'd8, 32'h34, 32'h0, 1'b0);          // LL
    idle_clear();
    issue(4'd9, 32'h34, 32'h11111111, 1'b0);   // SC fail after clear
    issue(4'd8, 32'h38, 32'h0, 1'b1);          // LL with clear in access
    issue(4'd8, 32'h38, 32'h0, 1'b0);          // LL
    issue(4'd9, 32'h38, 32'h22222222, 1'b1);   // SC with clear in access
    issue(4'd12, 32'h40, 32'h33333333, 1'b0);  // illegal op
    chk("mem_0x20", ram_w[8],  ref_word(32));
    chk("mem_0x30", ram_w[12], ref_word(48));

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] op;
      int         a;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 9)) : 4'($urandom_range(0, 15));
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 0) a = a & ~3;
      issue(op, a, $urandom, ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 9) == 0) idle_clear();
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    for (int i = 0; i < 64; i++) chk("final_mem", ram_w[i], ref_word(4*i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

- Initiator-side controller for the word-organised, byte-laned data RAM in the memory stage.
- Accepts one load/store request at a time from the pipeline and drives the RAM port: `ce`, `we`, 4-bit byte-lane `sel`, word address, store data.
- Returns load results sign- or zero-extended, flags misaligned addresses, and holds the LL/SC link bit.
- Fixed two-cycle request/response; the pipeline stalls on `req_ready`.

## Interface
- ADDR_W, 32, byte-address width; RAM address bus width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW, 8 LL, 9 SC; 10–15 illegal.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- llbit_clear  in  1  clear link bit (exception/ERET).
- ram_ce  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_sel  out  4  byte-lane enables; sel[3] = data[31:24].
- ram_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0).
- ram_wdata  out  32  lane-replicated store data.
- ram_rdata  in  32  RAM combinational read data.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  32  load result; SC: 1 = success, 0 = fail; other stores: 0.
- resp_exc  out  1  address-error exception.
- resp_exc_store  out  1  with resp_exc: 1 = AdES (store/SC), 0 = AdEL (load/LL).
- llbit  out  1  current link bit.

## Operation
- States: IDLE, ACCESS.
  - IDLE -> ACCESS on `req_valid && req_ready`; request fields are registered.
  - ACCESS -> IDLE unconditionally.
- Byte order is big-endian. Address offset 0 maps to lane 3 ([31:24]) and offset 3 to lane 0.
- Byte ops:
  - sel = 4'b1000 >> addr[1:0].
  - SB: ram_wdata = {4{wdata[7:0]}}.
- Half ops require addr[0] = 0:
  - addr[1] = 0 -> sel 4'b1100; addr[1] = 1 -> sel 4'b0011.
  - SH: ram_wdata = {2{wdata[15:0]}}.
- Word ops (LW, SW, LL, SC) require addr[1:0] = 0; sel 4'b1111.
- Load extraction: take the selected lane(s) of ram_rdata. LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned request: ram_ce = 0 during ACCESS, no RAM access; resp_exc = 1; resp_data = 0; llbit unchanged.
- Illegal op: ram_ce = 0; resp_exc = 0; resp_data = 0.
- LL:
  - Performs a word load.
  - Sets llbit at the end of ACCESS, unless llbit_clear is high that cycle (clear wins).
- SC:
  - Succeeds iff llbit = 1 and llbit_clear = 0 during ACCESS.
  - On success: ram_we = 1, word written, resp_data = 1.
  - On failure: ram_ce = 0, resp_data = 0.
  - llbit cleared at end of ACCESS in both cases.
- Outside ACCESS: ram_ce = 0, ram_we = 0, ram_sel = 0. ram_addr and ram_wdata are don't-care.

## Timing
- Request accepted at edge E0. ACCESS occupies cycle E0–E1, with RAM outputs driven from registers.
- RAM write commits at E1. Load data is sampled from ram_rdata at E1.
- resp_valid, resp_data and resp_exc are registered and valid in cycle E1–E2 for exactly one cycle. req_ready = 1 in that same cycle.
- Back-to-back throughput: one request per 2 cycles. Load/store latency is 2 cycles from acceptance to response.
- Reset:
  - Values: state = IDLE, req_ready = 1, resp_valid = 0, resp_data = 0, resp_exc = 0, resp_exc_store = 0, llbit = 0.
  - RAM outputs are 0 while rst = 1.
  - ram_ce and ram_we are gated combinationally with !rst. Reset asserted during ACCESS therefore aborts the access with no RAM write, and no response is issued.
- llbit_clear in IDLE clears llbit at the next edge.
- req_valid while req_ready = 0 is ignored. The requester holds the request until accepted.

## Test plan
- Reset mid-SW:
  - SW 0xDEADBEEF to 0x10; rst asserted in ACCESS -> no resp_valid, word at 0x10 unchanged.
  - After reset: req_ready = 1, llbit = 0.
- Full-word round trip: SW 0x12345678 @0x20, then LW @0x20 -> ram_sel 1111 on both; resp_data 0x12345678; resp_valid exactly 2 cycles after each acceptance.
- Byte/half lanes (word @0x20 = 0x12345678):
  - SB 0x80 @0x21 -> ram_sel 0100, ram_wdata 0x80808080.
  - LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080.
  - LH @0x22 -> sel 0011, result 0x00005678.
- Misalignment:
  - LW @0x22 -> ram_ce stays 0; resp_exc = 1, resp_exc_store = 0.
  - SH @0x23 -> resp_exc = 1, resp_exc_store = 1; memory unchanged.
- LL/SC pair:
  - LL @0x30 -> llbit = 1. SC 0xA5A5A5A5 @0x30 -> resp_data 1, word written, llbit = 0.
  - Second SC -> resp_data 0, ram_ce 0 throughout.
- LL/SC with interference:
  - LL, then llbit_clear pulse in IDLE, then SC -> fail.
  - LL with llbit_clear high in its ACCESS cycle -> llbit stays 0.
